// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with an optional prescaler.
//
// A start value is loaded and the timer counts down to zero. It only counts on
// cycles with en high. One edge after reaching zero it raises a single-cycle
// expired pulse. Each visible count step lasts 2^HIDDEN_BITS enabled cycles,
// because the counter carries HIDDEN_BITS extra prescaler bits below the visible
// count.
//
// Build option (preprocessor macro):
//   DOWN_TIMER_AUTO_RELOAD_EN - when defined, expiry reloads the last loaded value
//                               and the timer keeps running (periodic pulses).
//                               When undefined, the timer is one-shot.
//
// Parameters:
//   COUNT_BITS   width of the visible count and of load_value
//   HIDDEN_BITS  prescaler bits below the visible count
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   load        load request; restarts the timer, wins over everything but reset
//   load_value  start value captured on load
//   en          count enable
//   count       visible count (upper COUNT_BITS of the internal counter)
//   busy        timer running (loaded, not yet expired)
//   expired     registered single-cycle expiry pulse
module down_timer #(
  parameter int unsigned COUNT_BITS  = 6,
  parameter int unsigned HIDDEN_BITS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [COUNT_BITS-1:0] load_value,
  input  logic                  en,
  output logic [COUNT_BITS-1:0] count,
  output logic                  busy,
  output logic                  expired
);

  localparam int unsigned CtrBits = COUNT_BITS + HIDDEN_BITS;

  // The hidden bits load as all ones, so every visible value lasts a full
  // 2^HIDDEN_BITS enabled cycles. This also works when HIDDEN_BITS is 0, where a
  // zero-width replication would not be legal.
  localparam logic [CtrBits-1:0] HiddenOnes = CtrBits'((1 << HIDDEN_BITS) - 1);

  function automatic logic [CtrBits-1:0] load_pattern(input logic [COUNT_BITS-1:0] value);
    return (CtrBits'(value) << HIDDEN_BITS) | HiddenOnes;
  endfunction

  logic [CtrBits-1:0] ctr_q, ctr_d;
  logic               busy_q, busy_d;
  logic               expired_q, expired_d;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [COUNT_BITS-1:0] reload_q, reload_d;
`endif

  logic count_step;
  logic at_zero;

  // A count or expiry step happens only while running and enabled. A load in the
  // same cycle takes precedence, which suppresses a coincident expiry.
  assign count_step = busy_q && en && !load;
  assign at_zero    = (ctr_q == '0);

  always_comb begin
    ctr_d     = ctr_q;
    busy_d    = busy_q;
    expired_d = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif

    if (load) begin
      ctr_d    = load_pattern(load_value);
      busy_d   = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
    end else if (count_step) begin
      if (!at_zero) begin
        ctr_d = ctr_q - CtrBits'(1);
      end else begin
        expired_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        ctr_d     = load_pattern(reload_q);
`else
        // ctr is already zero, so count reads 0 while idle.
        busy_d    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctr_q     <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      ctr_q     <= ctr_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign count   = ctr_q[CtrBits-1:HIDDEN_BITS];
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer. Two instances are used: A with the default
// parameters (HIDDEN_BITS=0) and B with HIDDEN_BITS=2. Every edge compares both
// instances against a behavioural model. The model tracks how many enabled
// cycles remain until expiry, rather than mirroring the counter.
module tb_down_timer;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       clk;
  logic       rst_a, load_a, en_a, busy_a, expired_a;
  logic [5:0] lv_a, count_a;
  logic       rst_b, load_b, en_b, busy_b, expired_b;
  logic [5:0] lv_b, count_b;

  int checks = 0;
  int errors = 0;

  down_timer #(.COUNT_BITS(6), .HIDDEN_BITS(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .load(load_a), .load_value(lv_a), .en(en_a),
    .count(count_a), .busy(busy_a), .expired(expired_a)
  );

  down_timer #(.COUNT_BITS(6), .HIDDEN_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .load(load_b), .load_value(lv_b), .en(en_b),
    .count(count_b), .busy(busy_b), .expired(expired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tl = enabled, non-load edges remaining until the expiry edge.
  typedef struct {
    bit busy;
    int tl;
    int reload;
    bit exp;
  } mstate_t;

  mstate_t ma = '{busy: 1'b0, tl: 0, reload: 0, exp: 1'b0};
  mstate_t mb = '{busy: 1'b0, tl: 0, reload: 0, exp: 1'b0};

  function automatic mstate_t mstep(input mstate_t s, input bit rst, input bit load,
                                    input int lv, input bit en, input int h);
    mstate_t n = s;
    n.exp = 1'b0;
    if (!rst) begin
      n.busy = 1'b0; n.tl = 0; n.reload = 0;
    end else if (load) begin
      n.busy = 1'b1; n.tl = (lv + 1) << h; n.reload = lv;
    end else if (s.busy && en) begin
      n.tl = s.tl - 1;
      if (n.tl == 0) begin
        n.exp = 1'b1;
        if (Auto) n.tl = (s.reload + 1) << h;
        else n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic int mcount(input mstate_t s, input int h);
    return s.busy ? ((s.tl - 1) >> h) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: the model consumes the same inputs, then both DUTs are compared.
  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, rst_a, load_a, lv_a, en_a, 0);
    mb = mstep(mb, rst_b, load_b, lv_b, en_b, 2);
    #1;
    chk("a_count", count_a, mcount(ma, 0));
    chk("a_busy", busy_a, ma.busy);
    chk("a_expired", expired_a, ma.exp);
    chk("b_count", count_b, mcount(mb, 2));
    chk("b_busy", busy_b, mb.busy);
    chk("b_expired", expired_b, mb.exp);
  endtask

  typedef struct {
    bit         rst;
    bit         load;
    logic [5:0] lv;
    bit         en;
    int         cnt;
    bit         bsy;
    bit         exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit load, input int lv, input bit en,
                              input int cnt, input bit bsy, input bit exp);
    vec_t v;
    v.rst = rst; v.load = load; v.lv = 6'(lv); v.en = en;
    v.cnt = cnt; v.bsy = bsy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  int n;
  int enc;
  int pulses;
  bit found;

  initial begin
    rst_a = 1'b0; load_a = 1'b0; lv_a = '0; en_a = 1'b0;
    rst_b = 1'b0; load_b = 1'b0; lv_b = '0; en_b = 1'b0;

    // Reset held with load and en active.
    for (int i = 0; i < 4; i++) add(0, 1, 33, 1, 0, 0, 0);
    // One-shot from 5.
    add(1, 1, 5, 1, 5, 1, 0);
    for (int c = 4; c >= 0; c--) add(1, 0, 0, 1, c, 1, 0);
    add(1, 0, 0, 1, Auto ? 5 : 0, Auto, 1);
    add(1, 0, 0, 1, Auto ? 4 : 0, Auto, 0);
    // Load at the would-expire edge: no pulse, restart from 7.
    add(1, 1, 2, 1, 2, 1, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 7, 1, 7, 1, 0);
    add(1, 0, 0, 1, 6, 1, 0);
    // Reset mid-count at count 3: aborts with no pulse.
    add(1, 1, 5, 1, 5, 1, 0);
    add(1, 0, 0, 1, 4, 1, 0);
    add(1, 0, 0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    // Load 0; en low holds a pending expiry.
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, Auto, 1);
    // Full-range value.
    add(1, 1, 63, 1, 63, 1, 0);
    add(1, 0, 0, 1, 62, 1, 0);

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst; load_a = vecs[i].load; lv_a = vecs[i].lv; en_a = vecs[i].en;
      tick();
      chk($sformatf("vec%0d_count", i), count_a, vecs[i].cnt);
      chk($sformatf("vec%0d_busy", i), busy_a, vecs[i].bsy);
      chk($sformatf("vec%0d_expired", i), expired_a, vecs[i].exp);
    end

    // Prescaled instance: load 3, expiry pulse seen 16 edges after the load.
    rst_a = 1'b0; load_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b1; load_b = 1'b1; lv_b = 6'd3; en_b = 1'b1;
    tick();
    load_b = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      tick();
      n++;
      if (n < 16) chk("prescale_hold", count_b, (15 - n) >> 2);
      if (expired_b) found = 1'b1;
    end
    chk("prescale_latency", n, 16);

    // Enable gating on A: load 10, random en; expiry after exactly 11 en-high edges.
    rst_b = 1'b0;
    rst_a = 1'b1; load_a = 1'b1; lv_a = 6'd10; en_a = 1'b1;
    tick();
    load_a = 1'b0;
    n = 0; enc = 0; found = 1'b0;
    while (!found && n < 400) begin
      en_a = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (en_a) enc++;
      if (expired_a) found = 1'b1;
    end
    chk("gate_en_cycles", enc, 11);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // Periodic mode: load 2 then 20 enabled edges give a pulse every 3rd edge.
    load_a = 1'b1; lv_a = 6'd2; en_a = 1'b1;
    tick();
    load_a = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (expired_a) pulses++;
      chk("auto_busy", busy_a, 1);
    end
    chk("auto_pulses", pulses, 6);
`endif

    // Random traffic on both instances.
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_a  = ($urandom_range(0, 49) != 0);
      rst_b  = ($urandom_range(0, 49) != 0);
      load_a = ($urandom_range(0, 15) == 0);
      load_b = ($urandom_range(0, 31) == 0);
      lv_a   = 6'($urandom_range(0, 63));
      lv_b   = 6'($urandom_range(0, 7));
      en_a   = 1'($urandom_range(0, 1));
      en_b   = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
